bcd_display_loader: RTL and testbench
=====================================

Name: bcd_display_loader

Overview:
- Upstream feeder for the four-digit seven-segment scan path.
- Accepts a binary value over a valid/ready handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble), one bit per clock.
- Commits the result to a display register and presents the nibble for the digit currently selected by the scan selector (digit_select_2bit) to the digit multiplexor/segment decoder.
- Also flags leading zeros so the decoder can blank them.

Parameters:
- BIN_WIDTH, 14, width of binary input; also the number of conversion iterations.
- NUM_DIGITS, 4, BCD digits held; fixed at 4 to match the 2-bit scan index.
- MAX_VALUE, 9999, largest displayable value; larger inputs are clamped.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- bin_in  input  BIN_WIDTH  binary value to display
- bin_valid  input  1  bin_in is valid
- bin_ready  output  1  block can accept a value (high only in IDLE)
- digit_select_2bit  input  2  current scan digit index, 0 = least significant
- bcd_digits  output  4*NUM_DIGITS  committed BCD value; digit 3 in [15:12]
- digit_value  output  4  nibble of bcd_digits selected by digit_select_2bit
- digit_blank  output  1  selected digit is a suppressed leading zero
- overflow  output  1  last committed value was clamped
- busy  output  1  conversion or commit in progress (inverse of bin_ready)

Behaviour:
- Reset (async, any state):
  - state = IDLE; bcd_digits = 0; overflow = 0.
  - Shift/BCD working registers = 0; bin_ready = 1; busy = 0.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - bin_ready = 1.
  - On a clock edge with bin_valid = 1: capture min(bin_in, MAX_VALUE) into the shift register, latch the clamp flag, clear the BCD accumulator, clear the iteration counter, go to CONVERT.
- CONVERT, one iteration per clock:
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - After BIN_WIDTH iterations (counter reaches BIN_WIDTH-1), go to COMMIT.
  - Arithmetic is unsigned; a nibble never exceeds 9 after a shift.
- COMMIT:
  - Load bcd_digits from the accumulator and overflow from the latched clamp flag, then return to IDLE.
  - Gating is per the Optional Feature.
- Latency without frame sync:
  - Accept at edge E0; shifts at E1..E14; commit at E15.
  - bcd_digits and bin_ready change after E15, 15 clocks after accept.
- Handshake and input rules:
  - bin_valid while busy is ignored; no queuing.
  - bin_in is sampled only at the accept edge; later changes have no effect.
  - bcd_digits and overflow hold their old values throughout CONVERT and COMMIT, so the display never tears.
- digit_value:
  - Combinational mux of bcd_digits by digit_select_2bit.
  - Changes in the same cycle as either input changes.
- digit_blank is 1 when the selected index is not 0 and that digit plus every higher digit are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Reset asserted mid-conversion or mid-commit aborts the operation immediately. No partial result ever reaches bcd_digits.
- Clamp: any bin_in > 9999 (including 10000..16383) commits 0x9999 with overflow = 1. The next in-range commit clears overflow.

Optional Feature:
- Macro: BCD_FRAME_SYNC_EN.
- When defined:
  - Register digit_select_2bit every clock (reset value 3).
  - COMMIT waits until a scan-frame wrap: previous index = 3 and current index = 0. Commit happens on that edge.
  - bin_ready stays 0 while waiting.
  - Result: a new value appears only at frame start.
- When undefined: COMMIT completes unconditionally in one cycle and the registered select logic is absent.

Test Plan:
1. Reset, drive bin_in = 1234, bin_valid for one cycle -> bin_ready low for 15 clocks; bcd_digits = 0x1234, overflow = 0, bin_ready = 1 after E15.
2. bin_in = 0 -> bcd_digits = 0x0000; digit_select_2bit 3/2/1 give digit_blank = 1; select 0 gives digit_value = 0, digit_blank = 0.
3. bin_in = 10000, then bin_in = 42 -> first commit 0x9999 with overflow = 1; second commit 0x0042 with overflow = 0; digit_blank = 1 for indices 3 and 2, 0 for indices 1 and 0.
4. Accept 5678, assert reset on the 7th CONVERT clock -> bcd_digits = 0, overflow = 0, bin_ready = 1 while reset is high. After release, accept 9 -> bcd_digits = 0x0009.
5. Hold bin_valid high continuously with bin_in switching 111 -> 222 mid-conversion -> first commit 0x0111; 222 is accepted only at the next IDLE edge, second commit 0x0222.
6. With BCD_FRAME_SYNC_EN defined, hold digit_select_2bit = 1 after conversion -> bcd_digits unchanged and bin_ready = 0. Step select 2 -> 3 -> 0 -> commit on the 3 -> 0 edge, bcd_digits = new value.

Source files
------------

// File: rtl/bcd_display_loader_if.sv
// Binary-in / BCD-out bus between a value producer, the BCD loader and the scan-path digit mux.
`timescale 1ns/1ps
interface bcd_display_loader_if #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
);
  logic [BIN_WIDTH-1:0]    bin_in;
  logic                    bin_valid;
  logic                    bin_ready;
  logic [1:0]              digit_select_2bit;
  logic [4*NUM_DIGITS-1:0] bcd_digits;
  logic [3:0]              digit_value;
  logic                    digit_blank;
  logic                    overflow;
  logic                    busy;

  // Producer / scan side.
  modport master (
    output bin_in, bin_valid, digit_select_2bit,
    input  bin_ready, bcd_digits, digit_value, digit_blank, overflow, busy
  );

  // Loader side.
  modport slave (
    input  bin_in, bin_valid, digit_select_2bit,
    output bin_ready, bcd_digits, digit_value, digit_blank, overflow, busy
  );
endinterface

// File: rtl/bcd_display_loader.sv
// Sequential double-dabble binary-to-BCD loader feeding the 4-digit scan path.
// Optional BCD_FRAME_SYNC_EN holds each commit until the scan index wraps 3 -> 0.
`timescale 1ns/1ps
module bcd_display_loader #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4,
  parameter int MAX_VALUE  = 9999
) (
  input  logic              clk,
  input  logic              reset,
  bcd_display_loader_if.slave bus,
  output logic [1:0]        state_dbg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BIN_WIDTH-1:0] MAX_BIN   = BIN_WIDTH'(MAX_VALUE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]           state;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BIN_WIDTH-1:0] shift_next;
  logic [BCD_W-1:0]     bcd_acc;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 clamp_flag;
  logic [BCD_W-1:0]     bcd_reg;
  logic                 ovf_reg;
  logic                 in_range;
  logic                 commit_ok;

  assign in_range = (bus.bin_in <= MAX_BIN);

  // Handshake: a value transfers on a rising clk edge where bin_valid and bin_ready
  // are both high; bin_ready is high only in IDLE, so valid while busy is dropped.
  assign bus.bin_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign state_dbg     = state;

`ifdef BCD_FRAME_SYNC_EN
  logic [1:0] sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= 2'd3;
    else       sel_q <= bus.digit_select_2bit;
  end

  assign commit_ok = (sel_q == 2'd3) && (bus.digit_select_2bit == 2'd0);
`else
  assign commit_ok = 1'b1;
`endif

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_acc[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
    end
    {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      bcd_acc    <= '0;
      iter_cnt   <= '0;
      clamp_flag <= 1'b0;
      bcd_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.bin_valid) begin
            shift_reg  <= in_range ? bus.bin_in : MAX_BIN;
            clamp_flag <= ~in_range;
            bcd_acc    <= '0;
            iter_cnt   <= '0;
            state      <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_acc   <= bcd_next;
          shift_reg <= shift_next;
          iter_cnt  <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER) state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (commit_ok) begin
            bcd_reg <= bcd_acc;
            ovf_reg <= clamp_flag;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd_digits = bcd_reg;
  assign bus.overflow   = ovf_reg;

  always_comb begin
    bus.digit_value = 4'd0;
    bus.digit_blank = 1'b0;
    case (bus.digit_select_2bit)
      2'd0: bus.digit_value = bcd_reg[3:0];
      2'd1: begin
        bus.digit_value = bcd_reg[7:4];
        bus.digit_blank = (bcd_reg[15:4] == 12'd0);
      end
      2'd2: begin
        bus.digit_value = bcd_reg[11:8];
        bus.digit_blank = (bcd_reg[15:8] == 8'd0);
      end
      default: begin
        bus.digit_value = bcd_reg[15:12];
        bus.digit_blank = (bcd_reg[15:12] == 4'd0);
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_display_loader.sv
// Directed plus randomized bench for bcd_display_loader against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bcd_display_loader;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  bcd_display_loader_if #(.BIN_WIDTH(14), .NUM_DIGITS(4)) bus ();

  bcd_display_loader #(.BIN_WIDTH(14), .NUM_DIGITS(4), .MAX_VALUE(9999)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int tests = 0;
  int fails = 0;
  logic [13:0] exp_q[$];
  int          last_val = 0;
  logic        last_ovf = 1'b0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int clamp_of(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    int c = clamp_of(v);
    logic [15:0] r;
    r[15:12] = 4'(c / 1000);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  function automatic logic [3:0] digit_of(input int v, input int idx);
    return 4'((clamp_of(v) / pow10(idx)) % 10);
  endfunction

  function automatic logic blank_of(input int v, input int idx);
    return (idx != 0) && (clamp_of(v) < pow10(idx));
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input int sel);
    bus.digit_select_2bit = 2'(sel);
    #1;
    check("digit_value", bus.digit_value, digit_of(last_val, sel));
    check("digit_blank", bus.digit_blank, blank_of(last_val, sel));
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [13:0] v);
    @(negedge clk);
    bus.bin_in    = v;
    bus.bin_valid = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    bus.bin_valid = 1'b0;
    bus.bin_in    = 14'($urandom_range(0, 16383));
    check("accept_ready_low", bus.bin_ready, 1'b0);
  endtask

  // Wait for return to IDLE; display must hold the previous commit meanwhile.
  task automatic wait_done(input bit check_lat);
    int cycles = 0;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.bin_ready) done = 1'b1;
      else begin
        cycles++;
        check("hold_bcd", bus.bcd_digits, bcd_of(last_val));
        check("busy_high", bus.busy, 1'b1);
        @(negedge clk);
`ifdef BCD_FRAME_SYNC_EN
        bus.digit_select_2bit = bus.digit_select_2bit + 2'd1;
`endif
      end
    end
    check("done_timeout", bus.bin_ready, 1'b1);
`ifndef BCD_FRAME_SYNC_EN
    if (check_lat) check("latency", cycles, 15);
`endif
  endtask

  task automatic check_commit();
    int v;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", exp_q.size(), 1);
    end else begin
      v = int'(exp_q.pop_front());
      last_val = v;
      last_ovf = (v > 9999);
      check("bcd_digits", bus.bcd_digits, bcd_of(v));
      check("overflow", bus.overflow, last_ovf);
      check("busy_low", bus.busy, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset                 = 1'b1;
    bus.bin_in            = '0;
    bus.bin_valid         = 1'b0;
    bus.digit_select_2bit = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd", bus.bcd_digits, 16'h0000);
    check("rst_ovf", bus.overflow, 1'b0);
    check("rst_ready", bus.bin_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;

    // Basic conversion and latency
    send(14'd1234);
    wait_done(1'b1);
    check_commit();
    check("t1_const", bus.bcd_digits, 16'h1234);

    // Zero: only digit 0 visible
    send(14'd0);
    wait_done(1'b1);
    check_commit();
    for (int s = 0; s < 4; s++) check_digit(s);

    // Clamp then in-range clears overflow
    send(14'd10000);
    wait_done(1'b1);
    check_commit();
    check("t3_clamp", bus.bcd_digits, 16'h9999);
    send(14'd42);
    wait_done(1'b1);
    check_commit();
    for (int s = 0; s < 4; s++) check_digit(s);

    // Reset mid-conversion
    send(14'd5678);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_bcd", bus.bcd_digits, 16'h0000);
    check("abort_ovf", bus.overflow, 1'b0);
    check("abort_ready", bus.bin_ready, 1'b1);
    exp_q.delete();
    last_val = 0;
    last_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send(14'd9);
    wait_done(1'b1);
    check_commit();

    // bin_valid held high; value change mid-conversion ignored
    @(negedge clk);
    bus.bin_in    = 14'd111;
    bus.bin_valid = 1'b1;
    exp_q.push_back(14'd111);
    repeat (4) @(negedge clk);
    bus.bin_in = 14'd222;
    wait_done(1'b0);
    check_commit();
    exp_q.push_back(14'd222);
    @(negedge clk);
    bus.bin_valid = 1'b0;
    check("reaccept_busy", bus.bin_ready, 1'b0);
    wait_done(1'b1);
    check_commit();

`ifdef BCD_FRAME_SYNC_EN
    // Commit waits for scan wrap 3 -> 0
    bus.digit_select_2bit = 2'd1;
    send(14'd4321);
    repeat (25) @(negedge clk);
    check("fs_wait_ready", bus.bin_ready, 1'b0);
    check("fs_wait_bcd", bus.bcd_digits, bcd_of(last_val));
    bus.digit_select_2bit = 2'd2;
    @(negedge clk);
    bus.digit_select_2bit = 2'd3;
    @(negedge clk);
    check("fs_pre_wrap", bus.bin_ready, 1'b0);
    bus.digit_select_2bit = 2'd0;
    @(negedge clk);
    check("fs_wrap_ready", bus.bin_ready, 1'b1);
    check_commit();
`endif

    // Randomized values, a quarter of them forced out of range
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 3) send(14'($urandom_range(10000, 16383)));
      else            send(14'($urandom_range(0, 9999)));
      wait_done(1'b1);
      check_commit();
      check_digit(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
